// File: rtl/regfile_mp_sb_if.sv
// ----------------------------------------------------------------------------
// regfile_mp_sb_if
// Bundles the issue-side (read + reserve + flush) and writeback-side
// (write) signals of the multi-port scoreboarded register file.
//
//   raddr     issue -> rf   NRD*AW    read addresses, port i at [i*AW +: AW]
//   rdata     rf -> issue   NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
//   rbusy     rf -> issue   NRD       source register of port i has a pending write
//   we        wb -> rf      1         writeback write enable
//   waddr     wb -> rf      AW        writeback register address
//   wdata     wb -> rf      XLEN      writeback data
//   rsv_valid issue -> rf   1         request to mark rsv_addr busy
//   rsv_addr  issue -> rf   AW        destination register to reserve
//   rsv_ready rf -> issue   1         reservation accepted this cycle
//   flush     issue -> rf   1         clear every busy bit
//   busy_cnt  rf -> issue   AW+1      registered number of busy registers
//
// master: pipeline side driving the file.  slave: the register file.
// ----------------------------------------------------------------------------
interface regfile_mp_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic                rsv_valid;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_ready;
    logic                flush;
    logic [AW:0]         busy_cnt;

    modport master (
        output raddr, we, waddr, wdata, rsv_valid, rsv_addr, flush,
        input  rdata, rbusy, rsv_ready, busy_cnt
    );

    modport slave (
        input  raddr, we, waddr, wdata, rsv_valid, rsv_addr, flush,
        output rdata, rbusy, rsv_ready, busy_cnt
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// ----------------------------------------------------------------------------
// regfile_mp_sb
// Integer register file with NRD combinational read ports, one write port,
// write-to-read bypass, per-register busy scoreboard with a reserve
// handshake, pipeline flush and a registered busy counter.
//
// Ports:
//   clk     rising-edge clock for all state
//   resetn  asynchronous active-low reset (registers, busy bits, counter)
//   bus     regfile_mp_sb_if.slave, see the interface header for signals
//
// Register 0 reads as zero, ignores writes and never becomes busy.
// ----------------------------------------------------------------------------
module regfile_mp_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  logic            clk,
    input  logic            resetn,
    regfile_mp_sb_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;

    logic             wr_en_s;
    logic             rsv_ready_s;
    logic             rsv_set_s;
    logic             cnt_inc_s;
    logic             cnt_dec_s;
    logic [AW-1:0]    rd_addr_s [NRD];

    // Write qualification, reserve handshake and busy-counter deltas.
    always_comb begin
        wr_en_s     = bus.we && (bus.waddr != {AW{1'b0}});
        // WAW stall only when the target is busy and not being retired now.
        rsv_ready_s = !(busy_q[bus.rsv_addr] &&
                        !(bus.we && (bus.waddr == bus.rsv_addr)));
        // A flush discards any reservation in the same cycle.
        rsv_set_s   = bus.rsv_valid && rsv_ready_s &&
                      (bus.rsv_addr != {AW{1'b0}}) && !bus.flush;
        cnt_inc_s   = rsv_set_s && !busy_q[bus.rsv_addr];
        // A write retiring a busy register that is re-reserved leaves it busy.
        cnt_dec_s   = wr_en_s && busy_q[bus.waddr] &&
                      !(rsv_set_s && (bus.rsv_addr == bus.waddr));
    end

    // Next-state for register contents, busy vector and busy counter.
    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q;
        if (wr_en_s) begin
            regs_d[bus.waddr] = bus.wdata;
            busy_d[bus.waddr] = 1'b0;
        end else begin
            regs_d = regs_q;
        end
        // Applied after the write so a same-cycle reserve wins.
        if (rsv_set_s) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        if (bus.flush) begin
            busy_d     = {NREGS{1'b0}};
            busy_cnt_d = {(AW+1){1'b0}};
        end else begin
            busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, cnt_inc_s}
                                    - {{AW{1'b0}}, cnt_dec_s};
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
            busy_q     <= {NREGS{1'b0}};
            busy_cnt_q <= {(AW+1){1'b0}};
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Read ports: zero register, write bypass, then stored value.
    always_comb begin
        bus.rdata = {(NRD*XLEN){1'b0}};
        bus.rbusy = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            rd_addr_s[i] = bus.raddr[i*AW +: AW];
            // During reset the bypass path must not leak wdata.
            if (!resetn || (rd_addr_s[i] == {AW{1'b0}})) begin
                bus.rdata[i*XLEN +: XLEN] = {XLEN{1'b0}};
                bus.rbusy[i]              = 1'b0;
            end else if (wr_en_s && (bus.waddr == rd_addr_s[i])) begin
                bus.rdata[i*XLEN +: XLEN] = bus.wdata;
                bus.rbusy[i]              = 1'b0;
            end else begin
                bus.rdata[i*XLEN +: XLEN] = regs_q[rd_addr_s[i]];
                bus.rbusy[i]              = busy_q[rd_addr_s[i]];
            end
        end
    end

    assign bus.rsv_ready = rsv_ready_s;
    assign bus.busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp_sb
// Directed bench for regfile_mp_sb: a 2-read-port instance for most
// scenarios and a 4-read-port instance for the wide bypass case.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// a further unit later, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_regfile_mp_sb;
    logic clk;
    logic resetn;
    int   vec_cnt;
    int   err_cnt;

    regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus2 ();
    regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NRD(4)) bus4 ();

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2)) dut2 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus2.slave)
    );

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(4)) dut4 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus2.raddr = 10'd0; bus2.we = 1'b0; bus2.waddr = 5'd0; bus2.wdata = 32'd0;
        bus2.rsv_valid = 1'b0; bus2.rsv_addr = 5'd0; bus2.flush = 1'b0;
        bus4.raddr = 20'd0; bus4.we = 1'b0; bus4.waddr = 5'd0; bus4.wdata = 32'd0;
        bus4.rsv_valid = 1'b0; bus4.rsv_addr = 5'd0; bus4.flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        // Bypass must be suppressed while reset is asserted.
        bus2.raddr = {5'd5, 5'd5}; bus2.we = 1'b1; bus2.waddr = 5'd5; bus2.wdata = 32'h1111_2222;
        #3;
        vec_cnt++;
        if (bus2.rdata !== 64'd0) begin
            err_cnt++; $display("FAIL reset_bypass rdata=%h expected=%h", bus2.rdata, 64'd0);
        end
        vec_cnt++;
        if (bus2.rsv_ready !== 1'b1 || bus2.rbusy !== 2'b00) begin
            err_cnt++; $display("FAIL reset_ready ready=%b rbusy=%b expected 1/00", bus2.rsv_ready, bus2.rbusy);
        end
        idle();
        #10;
        resetn = 1'b1;
        tick();
        for (int r = 0; r < 32; r++) begin
            bus2.raddr = {5'(r), 5'(r)};
            #1;
            vec_cnt++;
            if (bus2.rdata !== 64'd0 || bus2.rbusy !== 2'b00) begin
                err_cnt++;
                $display("FAIL reset_read x%0d rdata=%h rbusy=%b expected 0/00", r, bus2.rdata, bus2.rbusy);
            end
        end
        vec_cnt++;
        if (bus2.busy_cnt !== 6'd0) begin
            err_cnt++; $display("FAIL reset_cnt busy_cnt=%0d expected=0", bus2.busy_cnt);
        end
    endtask

    task automatic test_midrun_reset();
        idle();
        bus2.we = 1'b1; bus2.waddr = 5'd5; bus2.wdata = 32'hDEAD_BEEF;
        bus2.rsv_valid = 1'b1; bus2.rsv_addr = 5'd8;
        tick();
        idle();
        bus2.raddr = {5'd8, 5'd5};
        #1;
        vec_cnt++;
        if (bus2.rdata[31:0] !== 32'hDEAD_BEEF || bus2.rbusy !== 2'b10 || bus2.busy_cnt !== 6'd1) begin
            err_cnt++;
            $display("FAIL midrun_pre rdata0=%h rbusy=%b cnt=%0d expected DEADBEEF/10/1",
                     bus2.rdata[31:0], bus2.rbusy, bus2.busy_cnt);
        end
        resetn = 1'b0;
        #1;
        vec_cnt++;
        if (bus2.rdata[31:0] !== 32'd0 || bus2.rbusy !== 2'b00 || bus2.busy_cnt !== 6'd0) begin
            err_cnt++;
            $display("FAIL midrun_reset rdata0=%h rbusy=%b cnt=%0d expected 0/00/0",
                     bus2.rdata[31:0], bus2.rbusy, bus2.busy_cnt);
        end
        #2;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        idle();
        bus2.raddr = {5'd7, 5'd7}; bus2.we = 1'b1; bus2.waddr = 5'd7; bus2.wdata = 32'h1234_5678;
        #1;
        vec_cnt++;
        if (bus2.rdata !== {32'h1234_5678, 32'h1234_5678} || bus2.rbusy !== 2'b00) begin
            err_cnt++; $display("FAIL bypass_same rdata=%h rbusy=%b expected 1234567812345678/00", bus2.rdata, bus2.rbusy);
        end
        tick();
        bus2.we = 1'b0;
        #1;
        vec_cnt++;
        if (bus2.rdata[31:0] !== 32'h1234_5678) begin
            err_cnt++; $display("FAIL bypass_next rdata0=%h expected=12345678", bus2.rdata[31:0]);
        end
    endtask

    task automatic test_reg0();
        idle();
        bus2.raddr = {5'd7, 5'd0}; bus2.we = 1'b1; bus2.waddr = 5'd0; bus2.wdata = 32'hFFFF_FFFF;
        bus2.rsv_valid = 1'b1; bus2.rsv_addr = 5'd0;
        #1;
        vec_cnt++;
        if (bus2.rdata[31:0] !== 32'd0 || bus2.rsv_ready !== 1'b1 || bus2.rbusy[0] !== 1'b0) begin
            err_cnt++;
            $display("FAIL reg0_same rdata0=%h ready=%b rbusy0=%b expected 0/1/0",
                     bus2.rdata[31:0], bus2.rsv_ready, bus2.rbusy[0]);
        end
        tick();
        idle();
        bus2.raddr = {5'd7, 5'd0};
        #1;
        vec_cnt++;
        if (bus2.rdata !== {32'h1234_5678, 32'd0} || bus2.rbusy !== 2'b00 || bus2.busy_cnt !== 6'd0) begin
            err_cnt++;
            $display("FAIL reg0_after rdata=%h rbusy=%b cnt=%0d expected 1234567800000000/00/0",
                     bus2.rdata, bus2.rbusy, bus2.busy_cnt);
        end
    endtask

    task automatic test_waw();
        idle();
        bus2.rsv_valid = 1'b1; bus2.rsv_addr = 5'd3;
        #1;
        vec_cnt++;
        if (bus2.rsv_ready !== 1'b1) begin
            err_cnt++; $display("FAIL waw_first ready=%b expected=1", bus2.rsv_ready);
        end
        tick();
        bus2.rsv_valid = 1'b0; bus2.raddr = {5'd0, 5'd3};
        #1;
        vec_cnt++;
        if (bus2.rbusy[0] !== 1'b1 || bus2.busy_cnt !== 6'd1) begin
            err_cnt++; $display("FAIL waw_busy rbusy0=%b cnt=%0d expected 1/1", bus2.rbusy[0], bus2.busy_cnt);
        end
        bus2.rsv_valid = 1'b1;
        #1;
        vec_cnt++;
        if (bus2.rsv_ready !== 1'b0) begin
            err_cnt++; $display("FAIL waw_stall ready=%b expected=0", bus2.rsv_ready);
        end
        bus2.we = 1'b1; bus2.waddr = 5'd3; bus2.wdata = 32'h0000_00A5;
        #1;
        vec_cnt++;
        if (bus2.rsv_ready !== 1'b1 || bus2.rdata[31:0] !== 32'h0000_00A5 || bus2.rbusy[0] !== 1'b0) begin
            err_cnt++;
            $display("FAIL waw_release ready=%b rdata0=%h rbusy0=%b expected 1/000000A5/0",
                     bus2.rsv_ready, bus2.rdata[31:0], bus2.rbusy[0]);
        end
        tick();
        idle();
        bus2.raddr = {5'd0, 5'd3};
        #1;
        vec_cnt++;
        if (bus2.rdata[31:0] !== 32'h0000_00A5 || bus2.rbusy[0] !== 1'b1 || bus2.busy_cnt !== 6'd1) begin
            err_cnt++;
            $display("FAIL waw_after rdata0=%h rbusy0=%b cnt=%0d expected 000000A5/1/1",
                     bus2.rdata[31:0], bus2.rbusy[0], bus2.busy_cnt);
        end
        // Plain writeback retires the reservation.
        bus2.we = 1'b1; bus2.waddr = 5'd3; bus2.wdata = 32'h0000_005A;
        tick();
        idle();
        bus2.raddr = {5'd0, 5'd3};
        #1;
        vec_cnt++;
        if (bus2.rdata[31:0] !== 32'h0000_005A || bus2.rbusy[0] !== 1'b0 || bus2.busy_cnt !== 6'd0) begin
            err_cnt++;
            $display("FAIL waw_retire rdata0=%h rbusy0=%b cnt=%0d expected 0000005A/0/0",
                     bus2.rdata[31:0], bus2.rbusy[0], bus2.busy_cnt);
        end
    endtask

    task automatic test_flush();
        logic [4:0] rsv_list [3];
        rsv_list[0] = 5'd1; rsv_list[1] = 5'd2; rsv_list[2] = 5'd4;
        idle();
        for (int k = 0; k < 3; k++) begin
            bus2.rsv_valid = 1'b1; bus2.rsv_addr = rsv_list[k];
            tick();
        end
        idle();
        bus2.raddr = {5'd2, 5'd1};
        #1;
        vec_cnt++;
        if (bus2.busy_cnt !== 6'd3 || bus2.rbusy !== 2'b11) begin
            err_cnt++; $display("FAIL flush_pre cnt=%0d rbusy=%b expected 3/11", bus2.busy_cnt, bus2.rbusy);
        end
        bus2.flush = 1'b1; bus2.we = 1'b1; bus2.waddr = 5'd2; bus2.wdata = 32'h0000_0055;
        bus2.rsv_valid = 1'b1; bus2.rsv_addr = 5'd6;
        #1;
        vec_cnt++;
        if (bus2.rsv_ready !== 1'b1) begin
            err_cnt++; $display("FAIL flush_ready ready=%b expected=1", bus2.rsv_ready);
        end
        tick();
        idle();
        bus2.raddr = {5'd6, 5'd2};
        #1;
        vec_cnt++;
        if (bus2.busy_cnt !== 6'd0 || bus2.rbusy !== 2'b00 || bus2.rdata[31:0] !== 32'h0000_0055) begin
            err_cnt++;
            $display("FAIL flush_after cnt=%0d rbusy=%b rdata0=%h expected 0/00/00000055",
                     bus2.busy_cnt, bus2.rbusy, bus2.rdata[31:0]);
        end
        bus2.raddr = {5'd4, 5'd1};
        #1;
        vec_cnt++;
        if (bus2.rbusy !== 2'b00) begin
            err_cnt++; $display("FAIL flush_x1x4 rbusy=%b expected=00", bus2.rbusy);
        end
    endtask

    task automatic test_four_port();
        idle();
        bus4.rsv_valid = 1'b1; bus4.rsv_addr = 5'd9;
        tick();
        idle();
        bus4.raddr = {5'd9, 5'd9, 5'd9, 5'd9};
        #1;
        vec_cnt++;
        if (bus4.rbusy !== 4'b1111 || bus4.busy_cnt !== 6'd1) begin
            err_cnt++; $display("FAIL quad_busy rbusy=%b cnt=%0d expected 1111/1", bus4.rbusy, bus4.busy_cnt);
        end
        bus4.we = 1'b1; bus4.waddr = 5'd9; bus4.wdata = 32'hCAFE_F00D;
        #1;
        vec_cnt++;
        if (bus4.rdata !== {4{32'hCAFE_F00D}} || bus4.rbusy !== 4'b0000) begin
            err_cnt++; $display("FAIL quad_bypass rdata=%h rbusy=%b expected 4xCAFEF00D/0000", bus4.rdata, bus4.rbusy);
        end
        tick();
        idle();
        bus4.raddr = {5'd0, 5'd9, 5'd9, 5'd9};
        #1;
        vec_cnt++;
        if (bus4.rdata !== {32'd0, {3{32'hCAFE_F00D}}} || bus4.rbusy !== 4'b0000 || bus4.busy_cnt !== 6'd0) begin
            err_cnt++;
            $display("FAIL quad_after rdata=%h rbusy=%b cnt=%0d expected 0+3xCAFEF00D/0000/0",
                     bus4.rdata, bus4.rbusy, bus4.busy_cnt);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_midrun_reset();
        test_bypass();
        test_reg0();
        test_waw();
        test_flush();
        test_four_port();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
